// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the cache line-fill block.
// State encoding, tag bit positions and line-offset arithmetic.
package cache_fill_pkg;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_REQ,
        FILL_BEATS,
        FILL_DONE
    } fill_state_t;

    localparam int MEMREQ_READ = 12;
    localparam int BEAT_BYTES  = 8;

    function automatic int line_offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/cache_line_fill_if.sv
// Cache-side miss/fill handshake plus arbiter request/response bus.
// slave = the fill block, master = cache and arbiter environment.
interface cache_line_fill_if #(
    parameter int WIDTH      = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int LINE_BYTES = 64
);
    logic                    miss_valid;
    logic [WIDTH-1:0]        miss_addr;
    logic                    miss_ready;
    logic                    fill_valid;
    logic [WIDTH-1:0]        fill_addr;
    logic [LINE_BYTES*8-1:0] fill_data;
    logic                    fill_error;
    logic                    fill_ready;
    logic                    arb_reqcyc;
    logic [WIDTH-1:0]        arb_req;
    logic [TAG_WIDTH-1:0]    arb_reqtag;
    logic                    arb_respcyc;
    logic [WIDTH-1:0]        arb_resp;
    logic [TAG_WIDTH-1:0]    arb_resptag;

    modport slave (
        input  miss_valid, miss_addr, fill_ready, arb_respcyc, arb_resp, arb_resptag,
        output miss_ready, fill_valid, fill_addr, fill_data, fill_error,
               arb_reqcyc, arb_req, arb_reqtag
    );

    modport master (
        output miss_valid, miss_addr, fill_ready, arb_respcyc, arb_resp, arb_resptag,
        input  miss_ready, fill_valid, fill_addr, fill_data, fill_error,
               arb_reqcyc, arb_req, arb_reqtag
    );
endinterface

// File: rtl/cache_line_fill_buffer.sv
// fill_line_buffer: line register written one beat at a time by index.
// Cleared on a new miss so unreceived beats always read back as zero.
module fill_line_buffer #(
    parameter int WORD_W     = 64,
    parameter int LINE_BEATS = 8,
    parameter int IDX_W      = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_we,
    input  logic [IDX_W-1:0]             i_idx,
    input  logic [WORD_W-1:0]            i_data,
    output logic [LINE_BEATS*WORD_W-1:0] o_line
);
    logic [LINE_BEATS*WORD_W-1:0] r_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line <= '0;
        end else if (i_clear) begin
            r_line <= '0;
        end else if (i_we) begin
            r_line[int'(i_idx)*WORD_W +: WORD_W] <= i_data;
        end
    end

    assign o_line = r_line;
endmodule

// File: rtl/cache_line_fill.sv
// Line-fill miss handler: one miss -> one tagged read -> LINE_BEATS beats -> fill.
// Optional watchdog abort enabled by defining CACHE_FILL_TIMEOUT_EN.
//   state      | meaning
//   FILL_IDLE  | miss_ready high, waiting for a miss
//   FILL_REQ   | arb_reqcyc high, waiting for the first beat (implicit grant)
//   FILL_BEATS | collecting the remaining beats
//   FILL_DONE  | fill_valid high until fill_ready
module cache_line_fill
    import cache_fill_pkg::*;
#(
    parameter int          WIDTH          = 64,
    parameter int          TAG_WIDTH      = 13,
    parameter int          LINE_BYTES     = 64,
    parameter logic [11:0] REQ_ID         = 12'h000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input logic           clk,
    input logic           reset,
    cache_line_fill_if.slave bus
);
    localparam int OFF        = line_offset_bits(LINE_BYTES);
    localparam int LINE_BEATS = LINE_BYTES / BEAT_BYTES;
    localparam int IDX_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int CNT_W      = $clog2(LINE_BEATS + 1);
    localparam logic [CNT_W-1:0]     LAST_IDX  = CNT_W'(LINE_BEATS - 1);
    localparam logic [WIDTH-1:0]     LINE_MASK = ~((WIDTH'(1) << OFF) - WIDTH'(1));
    localparam logic [TAG_WIDTH-1:0] READ_TAG  = TAG_WIDTH'(REQ_ID) | (TAG_WIDTH'(1) << MEMREQ_READ);

    fill_state_t          r_state, w_state_nxt;
    logic                 r_miss_ready, w_miss_ready_nxt;
    logic                 r_fill_valid, w_fill_valid_nxt;
    logic                 r_arb_reqcyc, w_reqcyc_nxt;
    logic [WIDTH-1:0]     r_arb_req, w_req_nxt;
    logic [TAG_WIDTH-1:0] r_arb_reqtag, w_reqtag_nxt;
    logic [WIDTH-1:0]     r_fill_addr, w_fill_addr_nxt;
    logic [CNT_W-1:0]     r_count, w_count_nxt;
    logic                 w_buf_clear, w_buf_we, w_beat_hit;
    logic [WIDTH-1:0]     w_line_addr;
`ifdef CACHE_FILL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]      r_wdog, w_wdog_nxt;
    logic                 r_fill_error, w_fill_error_nxt;
`endif

    assign w_line_addr = bus.miss_addr & LINE_MASK;
    assign w_beat_hit  = bus.arb_respcyc && (bus.arb_resptag == r_arb_reqtag);

    always_comb begin
        w_state_nxt      = r_state;
        w_miss_ready_nxt = r_miss_ready;
        w_fill_valid_nxt = r_fill_valid;
        w_reqcyc_nxt     = r_arb_reqcyc;
        w_req_nxt        = r_arb_req;
        w_reqtag_nxt     = r_arb_reqtag;
        w_fill_addr_nxt  = r_fill_addr;
        w_count_nxt      = r_count;
        w_buf_clear      = 1'b0;
        w_buf_we         = 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
        w_fill_error_nxt = r_fill_error;
        w_wdog_nxt       = r_wdog;
`endif
        case (r_state)
            FILL_IDLE: begin
                if (bus.miss_valid) begin
                    w_state_nxt      = FILL_REQ;
                    w_miss_ready_nxt = 1'b0;
                    w_reqcyc_nxt     = 1'b1;
                    w_req_nxt        = w_line_addr;
                    w_reqtag_nxt     = READ_TAG;
                    w_fill_addr_nxt  = w_line_addr;
                    w_count_nxt      = '0;
                    w_buf_clear      = 1'b1;
`ifdef CACHE_FILL_TIMEOUT_EN
                    w_wdog_nxt       = WD_LOAD;
`endif
                end
            end
            FILL_REQ, FILL_BEATS: begin
                // r_count is 0 in FILL_REQ, so the first beat lands at index 0
                if (w_beat_hit) begin
                    w_buf_we     = 1'b1;
                    w_reqcyc_nxt = 1'b0;
                    w_count_nxt  = r_count + CNT_W'(1);
`ifdef CACHE_FILL_TIMEOUT_EN
                    w_wdog_nxt   = WD_LOAD;
`endif
                    if (r_count == LAST_IDX) begin
                        w_state_nxt      = FILL_DONE;
                        w_fill_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = FILL_BEATS;
                    end
                end
`ifdef CACHE_FILL_TIMEOUT_EN
                else if (r_wdog == '0) begin
                    w_reqcyc_nxt     = 1'b0;
                    w_state_nxt      = FILL_DONE;
                    w_fill_valid_nxt = 1'b1;
                    w_fill_error_nxt = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog - WD_W'(1);
                end
`endif
            end
            FILL_DONE: begin
                if (bus.fill_ready) begin
                    w_state_nxt      = FILL_IDLE;
                    w_fill_valid_nxt = 1'b0;
                    w_miss_ready_nxt = 1'b1;
`ifdef CACHE_FILL_TIMEOUT_EN
                    w_fill_error_nxt = 1'b0;
`endif
                end
            end
            default: w_state_nxt = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FILL_IDLE;
            r_miss_ready <= 1'b1;
            r_fill_valid <= 1'b0;
            r_arb_reqcyc <= 1'b0;
            r_arb_req    <= '0;
            r_arb_reqtag <= '0;
            r_fill_addr  <= '0;
            r_count      <= '0;
`ifdef CACHE_FILL_TIMEOUT_EN
            r_fill_error <= 1'b0;
            r_wdog       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_miss_ready <= w_miss_ready_nxt;
            r_fill_valid <= w_fill_valid_nxt;
            r_arb_reqcyc <= w_reqcyc_nxt;
            r_arb_req    <= w_req_nxt;
            r_arb_reqtag <= w_reqtag_nxt;
            r_fill_addr  <= w_fill_addr_nxt;
            r_count      <= w_count_nxt;
`ifdef CACHE_FILL_TIMEOUT_EN
            r_fill_error <= w_fill_error_nxt;
            r_wdog       <= w_wdog_nxt;
`endif
        end
    end

    fill_line_buffer #(
        .WORD_W    (WIDTH),
        .LINE_BEATS(LINE_BEATS),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .i_clear(w_buf_clear),
        .i_we   (w_buf_we),
        .i_idx  (r_count[IDX_W-1:0]),
        .i_data (bus.arb_resp),
        .o_line (bus.fill_data)
    );

    assign bus.miss_ready = r_miss_ready;
    assign bus.fill_valid = r_fill_valid;
    assign bus.fill_addr  = r_fill_addr;
    assign bus.arb_reqcyc = r_arb_reqcyc;
    assign bus.arb_req    = r_arb_req;
    assign bus.arb_reqtag = r_arb_reqtag;
`ifdef CACHE_FILL_TIMEOUT_EN
    assign bus.fill_error = r_fill_error;
`else
    assign bus.fill_error = 1'b0;
`endif
endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: expected lines queued as beats are driven.
// Timeout scenario compiled only with CACHE_FILL_TIMEOUT_EN (TIMEOUT_CYCLES=16).
module tb_cache_line_fill;
    localparam int W  = 64;
    localparam int TW = 13;
    localparam int LB = 64;
    localparam int LW = LB * 8;
    localparam logic [TW-1:0] TAG_OK  = 13'h1000;
    localparam logic [TW-1:0] TAG_BAD = 13'h1001;

    typedef struct {
        logic [W-1:0]  addr;
        logic [LW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    cache_line_fill_if #(.WIDTH(W), .TAG_WIDTH(TW), .LINE_BYTES(LB)) bus();

    cache_line_fill #(
        .WIDTH(W), .TAG_WIDTH(TW), .LINE_BYTES(LB), .REQ_ID(12'h000), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [W-1:0] a);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a;
        tick();
        bus.miss_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [TW-1:0] t);
        bus.arb_respcyc = 1'b1;
        bus.arb_resp    = d;
        bus.arb_resptag = t;
        tick();
        bus.arb_respcyc = 1'b0;
    endtask

    task automatic wait_fill(output bit ok, output int n);
        n = 0;
        while (!bus.fill_valid && n < 200) begin
            tick();
            n++;
        end
        ok = bus.fill_valid;
    endtask

    task automatic release_fill();
        bus.fill_ready = 1'b1;
        tick();
        bus.fill_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.miss_valid = 0; bus.miss_addr = '0; bus.fill_ready = 0;
        bus.arb_respcyc = 0; bus.arb_resp = '0; bus.arb_resptag = '0;
        tick(); tick();
        total++; if (bus.miss_ready !== 1'b1) begin bad++; $display("FAIL reset_miss_ready got=%b want=1", bus.miss_ready); end
        total++; if ({bus.fill_valid, bus.fill_error, bus.arb_reqcyc} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.fill_valid, bus.fill_error, bus.arb_reqcyc}); end
        total++; if ({bus.arb_req, bus.arb_reqtag, bus.fill_addr} !== '0) begin bad++; $display("FAIL reset_regs req=%h tag=%h addr=%h want 0", bus.arb_req, bus.arb_reqtag, bus.fill_addr); end
        total++; if (bus.fill_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.fill_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        exp_t e; bit ok; int n;
        e.addr = 64'h1234_5640; e.err = 1'b0; e.data = '0;
        for (int i = 0; i < 8; i++) e.data[64*i +: 64] = 64'(i);
        sb.push_back(e);
        start_miss(64'h1234_5678);
        total++; if (bus.arb_req !== 64'h1234_5640) begin bad++; $display("FAIL basic_req got=%h want=%h", bus.arb_req, 64'h1234_5640); end
        total++; if (bus.arb_reqtag !== TAG_OK) begin bad++; $display("FAIL basic_tag got=%h want=%h", bus.arb_reqtag, TAG_OK); end
        total++; if ({bus.arb_reqcyc, bus.miss_ready} !== 2'b10) begin bad++; $display("FAIL basic_hs got=%b want=10", {bus.arb_reqcyc, bus.miss_ready}); end
        for (int i = 0; i < 8; i++) begin
            send_beat(64'(i), TAG_OK);
            // a one-cycle gap mid-line must leave the partial data in place
            if (i == 4) tick();
        end
        wait_fill(ok, n);
        total++; if (!ok) begin bad++; $display("FAIL basic_wait fill_valid=%b want=1", bus.fill_valid); end
        e = sb.pop_front();
        total++; if (bus.fill_data !== e.data) begin bad++; $display("FAIL basic_data got=%h want=%h", bus.fill_data, e.data); end
        total++; if ({bus.fill_addr, bus.fill_error} !== {e.addr, e.err}) begin bad++; $display("FAIL basic_addr got=%h/%b want=%h/%b", bus.fill_addr, bus.fill_error, e.addr, e.err); end
        release_fill();
        total++; if ({bus.fill_valid, bus.miss_ready} !== 2'b01) begin bad++; $display("FAIL basic_release got=%b want=01", {bus.fill_valid, bus.miss_ready}); end
    endtask

    task automatic test_backpressure();
        exp_t e; bit ok; int n; int errs;
        e.addr = 64'h0000_0000_0000_1FC0; e.err = 1'b0; e.data = '0;
        for (int i = 0; i < 8; i++) e.data[64*i +: 64] = 64'h5500_0000_0000_0000 | 64'(i);
        sb.push_back(e);
        start_miss(64'h0000_0000_0000_1FFF);
        for (int i = 0; i < 8; i++) send_beat(64'h5500_0000_0000_0000 | 64'(i), TAG_OK);
        wait_fill(ok, n);
        total++; if (!ok) begin bad++; $display("FAIL bp_wait fill_valid=%b want=1", bus.fill_valid); end
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 64'hFFFF_0000;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if ({bus.fill_valid, bus.miss_ready, bus.arb_reqcyc} !== 3'b100) errs++;
        end
        bus.miss_valid = 1'b0;
        total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d want=0", errs); end
        e = sb.pop_front();
        total++; if ({bus.fill_addr, bus.fill_data} !== {e.addr, e.data}) begin bad++; $display("FAIL bp_line addr=%h want=%h data=%h want=%h", bus.fill_addr, e.addr, bus.fill_data, e.data); end
        release_fill();
        total++; if ({bus.fill_valid, bus.miss_ready, bus.arb_reqcyc} !== 3'b010) begin bad++; $display("FAIL bp_release got=%b want=010", {bus.fill_valid, bus.miss_ready, bus.arb_reqcyc}); end
    endtask

    task automatic test_delayed_grant();
        exp_t e; bit ok; int n; int drops;
        e.addr = 64'hABCD_0000; e.err = 1'b0; e.data = '0;
        for (int i = 0; i < 8; i++) e.data[64*i +: 64] = 64'(i) * 64'h1111;
        sb.push_back(e);
        start_miss(64'hABCD_0004);
        bus.fill_ready = 1'b1;
        drops = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (bus.arb_reqcyc !== 1'b1) drops++;
        end
        bus.fill_ready = 1'b0;
        total++; if (drops !== 0) begin bad++; $display("FAIL grant_hold low_cycles=%0d want=0", drops); end
        send_beat(64'h0, TAG_OK);
        total++; if (bus.arb_reqcyc !== 1'b0) begin bad++; $display("FAIL grant_drop got=%b want=0", bus.arb_reqcyc); end
        for (int i = 1; i < 8; i++) send_beat(64'(i) * 64'h1111, TAG_OK);
        wait_fill(ok, n);
        total++; if (!ok) begin bad++; $display("FAIL grant_wait fill_valid=%b want=1", bus.fill_valid); end
        e = sb.pop_front();
        total++; if (bus.fill_data !== e.data) begin bad++; $display("FAIL grant_data got=%h want=%h", bus.fill_data, e.data); end
        release_fill();
    endtask

    task automatic test_tag_filter();
        exp_t e; bit ok; int n;
        e.addr = 64'h0000_0000_0BAD_F000; e.err = 1'b0; e.data = '0;
        for (int i = 0; i < 8; i++) e.data[64*i +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i);
        sb.push_back(e);
        start_miss(64'h0000_0000_0BAD_F030);
        send_beat(64'hDEAD_0000_0000_00FF, TAG_BAD);
        total++; if (bus.arb_reqcyc !== 1'b1) begin bad++; $display("FAIL tag_req_hold got=%b want=1", bus.arb_reqcyc); end
        for (int i = 0; i < 8; i++) begin
            send_beat(64'hA5A5_0000_0000_0000 | 64'(i), TAG_OK);
            send_beat(64'hDEAD_BEEF_0000_0000 | 64'(i), TAG_BAD);
        end
        // extra matching beats arrive in DONE and must be dropped
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, TAG_OK);
        send_beat(64'hEEEE_EEEE_EEEE_EEEE, TAG_OK);
        wait_fill(ok, n);
        total++; if (!ok) begin bad++; $display("FAIL tag_wait fill_valid=%b want=1", bus.fill_valid); end
        e = sb.pop_front();
        total++; if (bus.fill_data !== e.data) begin bad++; $display("FAIL tag_data got=%h want=%h", bus.fill_data, e.data); end
        total++; if (bus.fill_addr !== e.addr) begin bad++; $display("FAIL tag_addr got=%h want=%h", bus.fill_addr, e.addr); end
        release_fill();
    endtask

    task automatic test_reset_mid_fill();
        exp_t e; bit ok; int n;
        start_miss(64'h4444_4444);
        for (int i = 0; i < 3; i++) send_beat(64'hCC00 | 64'(i), TAG_OK);
        reset = 1'b1;
        #1;
        total++; if ({bus.miss_ready, bus.fill_valid, bus.arb_reqcyc} !== 3'b100) begin bad++; $display("FAIL rst_mid_flags got=%b want=100", {bus.miss_ready, bus.fill_valid, bus.arb_reqcyc}); end
        total++; if ({bus.arb_req, bus.arb_reqtag, bus.fill_addr, bus.fill_data} !== '0) begin bad++; $display("FAIL rst_mid_regs req=%h tag=%h data=%h want 0", bus.arb_req, bus.arb_reqtag, bus.fill_data); end
        tick();
        reset = 1'b0;
        tick();
        e.addr = 64'h7777_0000; e.err = 1'b0; e.data = '0;
        for (int i = 0; i < 8; i++) e.data[64*i +: 64] = 64'h100 + 64'(i);
        sb.push_back(e);
        start_miss(64'h7777_0013);
        total++; if ({bus.arb_reqcyc, bus.arb_req} !== {1'b1, e.addr}) begin bad++; $display("FAIL rst_new_req got=%b/%h want=1/%h", bus.arb_reqcyc, bus.arb_req, e.addr); end
        for (int i = 0; i < 8; i++) send_beat(64'h100 + 64'(i), TAG_OK);
        wait_fill(ok, n);
        total++; if (!ok) begin bad++; $display("FAIL rst_new_wait fill_valid=%b want=1", bus.fill_valid); end
        e = sb.pop_front();
        total++; if (bus.fill_data !== e.data) begin bad++; $display("FAIL rst_new_data got=%h want=%h", bus.fill_data, e.data); end
        release_fill();
    endtask

`ifdef CACHE_FILL_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e; bit ok; int n;
        e.addr = 64'h9000_0000; e.err = 1'b1; e.data = '0;
        e.data[63:0]   = 64'hBEEF_0000;
        e.data[127:64] = 64'hBEEF_0001;
        sb.push_back(e);
        start_miss(64'h9000_0008);
        send_beat(64'hBEEF_0000, TAG_OK);
        send_beat(64'hBEEF_0001, TAG_OK);
        wait_fill(ok, n);
        total++; if (!ok || n !== 16) begin bad++; $display("FAIL tmo_latency cycles=%0d want=16", n); end
        e = sb.pop_front();
        total++; if ({bus.fill_error, bus.arb_reqcyc} !== 2'b10) begin bad++; $display("FAIL tmo_flags got=%b want=10", {bus.fill_error, bus.arb_reqcyc}); end
        total++; if (bus.fill_data !== e.data) begin bad++; $display("FAIL tmo_data got=%h want=%h", bus.fill_data, e.data); end
        release_fill();
        total++; if ({bus.fill_error, bus.miss_ready} !== 2'b01) begin bad++; $display("FAIL tmo_release got=%b want=01", {bus.fill_error, bus.miss_ready}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_delayed_grant();
        test_tag_filter();
        test_reset_mid_fill();
`ifdef CACHE_FILL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
